// File: rtl/prll_bus_rr_sched.sv
// +------------------------------------------------------------------------+
// | Module : prll_bus_rr_sched                                             |
// | Brief  : round-robin owner scheduler for the shared mbc/spi/uart bus,  |
// |          with per-tenure beat limit and idle timeout                   |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module prll_bus_rr_sched #(
  parameter int DRVRS      = 3,
  parameter int MAX_BEATS  = 4,
  parameter int TMO_CYCLES = 16,
  localparam int ID_W      = (DRVRS > 1) ? $clog2(DRVRS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DRVRS-1:0] req,
  input  logic             wrt,
  output logic [DRVRS-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             bs_bsy,
  output logic             trn_chng,
  output logic             tmo_err,
  output logic [ID_W-1:0]  tmo_id
);

  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam int IDLE_W = $clog2(TMO_CYCLES + 1);
  localparam int SUM_W  = ID_W + 1;

  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(MAX_BEATS - 1);
  localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(TMO_CYCLES - 1);
  localparam logic [SUM_W-1:0]  c_drvrs     = SUM_W'(DRVRS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_RLS  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [DRVRS-1:0]    r_gnt;
  logic [ID_W-1:0]     r_gnt_id;
  logic                r_trn_chng;
  logic                r_tmo_err;
  logic [ID_W-1:0]     r_tmo_id;

  logic [ID_W-1:0]     w_win;
  logic                w_any;
  logic [SUM_W-1:0]    w_sum;
  logic [ID_W-1:0]     w_cand;
  logic                w_rel_req;
  logic                w_rel_beat;
  logic                w_rel_tmo;

  // Scan from farthest to nearest so the requester closest after r_ptr wins.
  always_comb begin
    w_win  = '0;
    w_any  = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = DRVRS; k >= 1; k--) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= c_drvrs) begin
        w_sum = w_sum - c_drvrs;
      end
      w_cand = w_sum[ID_W-1:0];
      if (req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_rel_req  = ~req[r_gnt_id];
  assign w_rel_beat = wrt & (r_beat_cnt == c_beat_last);
  assign w_rel_tmo  = ~wrt & (r_idle_cnt == c_idle_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= ID_W'(DRVRS - 1);
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_trn_chng <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo_id   <= '0;
    end else begin
      r_trn_chng <= 1'b0;
      r_tmo_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_RLS: begin
          if (w_any) begin
            r_state    <= S_OWN;
            r_gnt      <= DRVRS'(1) << w_win;
            r_gnt_id   <= w_win;
            r_ptr      <= w_win;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_trn_chng <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OWN: begin
          if (w_rel_req || w_rel_beat || w_rel_tmo) begin
            r_state <= S_RLS;
            r_gnt   <= '0;
            // A dropped request is a normal release even on the timeout cycle.
            if (w_rel_tmo && !w_rel_req) begin
              r_tmo_err <= 1'b1;
              r_tmo_id  <= r_gnt_id;
            end
          end else if (wrt) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign gnt_id   = r_gnt_id;
  assign bs_bsy   = |r_gnt;
  assign trn_chng = r_trn_chng;
  assign tmo_err  = r_tmo_err;
  assign tmo_id   = r_tmo_id;

endmodule

`default_nettype wire

// File: tb/tb_prll_bus_rr_sched.sv
// +------------------------------------------------------------------------+
// | Module : tb_prll_bus_rr_sched                                          |
// | Brief  : scoreboard bench for prll_bus_rr_sched against a tenure model |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_prll_bus_rr_sched;

  localparam int N   = 3;
  localparam int MB  = 4;
  localparam int TMO = 16;
  localparam int IDW = 2;

  logic           clk   = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req   = '0;
  logic           wrt   = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           bs_bsy;
  logic           trn_chng;
  logic           tmo_err;
  logic [IDW-1:0] tmo_id;

  prll_bus_rr_sched #(.DRVRS(N), .MAX_BEATS(MB), .TMO_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wrt      (wrt),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .bs_bsy   (bs_bsy),
    .trn_chng (trn_chng),
    .tmo_err  (tmo_err),
    .tmo_id   (tmo_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] gnt;
    bit           trn;
    bit           tmo;
  } exp_t;

  exp_t q_bus[$];
  int   q_gid[$];
  int   q_tid[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Tenure model: an owner id (or -1 for no owner) plus per-tenure tallies.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_beats = 0;
  int m_idle  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // Advance the model across the coming edge using the inputs now on the bus.
  task automatic model_step();
    exp_t e;
    e.gnt = '0;
    e.trn = 1'b0;
    e.tmo = 1'b0;
    if (m_owner < 0) begin
      int w;
      w = pick(req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_beats = 0;
        m_idle  = 0;
        e.trn   = 1'b1;
        q_gid.push_back(w);
      end
    end else begin
      bit ra, rb, rc;
      ra = !req[m_owner];
      rb = wrt && (m_beats + 1 == MB);
      rc = !wrt && (m_idle + 1 == TMO);
      if (ra || rb || rc) begin
        if (rc && !ra) begin
          e.tmo = 1'b1;
          q_tid.push_back(m_owner);
        end
        m_owner = -1;
      end else if (wrt) begin
        m_beats++;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (m_owner >= 0) e.gnt = N'(1) << m_owner;
    q_bus.push_back(e);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  // Release reset just after an edge and expect an idle bus in that cycle.
  task automatic start();
    exp_t e;
    m_owner = -1;
    m_last  = N - 1;
    m_beats = 0;
    m_idle  = 0;
    q_bus.delete();
    q_gid.delete();
    q_tid.delete();
    e.gnt = '0;
    e.trn = 1'b0;
    e.tmo = 1'b0;
    q_bus.push_back(e);
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_bus.size() == 0) begin
        chk("bus_queue_underflow", 1, 0);
      end else begin
        mon_e = q_bus.pop_front();
        chk("gnt", gnt, mon_e.gnt);
        chk("bs_bsy", bs_bsy, mon_e.gnt != '0);
        chk("trn_chng", trn_chng, mon_e.trn);
        chk("tmo_err", tmo_err, mon_e.tmo);
      end
      chk("gnt_onehot", $countones(gnt) <= 1, 1);
      if (trn_chng) begin
        if (q_gid.size() == 0) chk("unexpected_grant", 1, 0);
        else chk("gnt_id", gnt_id, q_gid.pop_front());
      end
      if (tmo_err) begin
        if (q_tid.size() == 0) chk("unexpected_timeout", 1, 0);
        else chk("tmo_id", tmo_id, q_tid.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    int guard;
    bit quiet;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_tmo_id", tmo_id, 0);
    start();

    // Idle bus with no requests.
    req = '0; wrt = 1'b0;
    repeat (10) cyc();

    // Everyone requests with a beat every cycle: rotation 0,1,2,0...
    req = 3'b111; wrt = 1'b1;
    repeat (22) cyc();

    // Lone requester 1 drops after two beats.
    req = 3'b010; wrt = 1'b1;
    guard = 0;
    while (!(m_owner == 1 && m_beats == 2) && guard < 40) begin cyc(); guard++; end
    chk("reach_owner1_two_beats", guard < 40, 1);
    req = 3'b000; wrt = 1'b0;
    repeat (4) cyc();

    // Silent owner 2 is timed out and regranted.
    req = 3'b100; wrt = 1'b0;
    repeat (40) cyc();

    // Owner 1 drops its request on its final beat.
    req = 3'b110; wrt = 1'b1;
    guard = 0;
    while (!(m_owner == 1 && m_beats == MB - 1) && guard < 60) begin cyc(); guard++; end
    chk("reach_owner1_last_beat", guard < 60, 1);
    req = 3'b100; wrt = 1'b1;
    cyc();
    repeat (6) cyc();
    req = 3'b000; wrt = 1'b0;
    repeat (3) cyc();

    // Randomised traffic, alternating busy and quiet write phases.
    for (int blk = 0; blk < 12; blk++) begin
      quiet = $urandom_range(0, 1);
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, quiet ? 15 : 3) == 0) req = N'($urandom);
        wrt = quiet ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1));
        cyc();
      end
    end
    req = '0; wrt = 1'b0;
    repeat (4) cyc();

    // Asynchronous reset in the middle of owner 0's tenure.
    req = 3'b011; wrt = 1'b1;
    guard = 0;
    while (!(m_owner == 0 && m_beats == 2) && guard < 60) begin cyc(); guard++; end
    chk("reach_owner0_two_beats", guard < 60, 1);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("async_reset_gnt", gnt, 0);
    chk("async_reset_bs_bsy", bs_bsy, 0);
    chk("async_reset_gnt_id", gnt_id, 0);
    chk("async_reset_tmo_id", tmo_id, 0);
    chk("async_reset_trn_chng", trn_chng, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start();
    req = 3'b011; wrt = 1'b0;
    repeat (3) cyc();
    req = '0;
    repeat (4) cyc();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("pending_grants", q_gid.size(), 0);
    chk("pending_timeouts", q_tid.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
